pipe3_core_param: RTL and testbench

- Parametrised successor of the team's 3-stage (Decode / Execute / Writeback) 16-bit-instruction processor.
- Generalised data and PC widths; configurable multiplier latency.
- Full forwarding, so back-to-back ALU ops never stall.
- Taken jumps/branches squash the wrong-path instruction; MFLO/MFHI/MUL interlock against a busy multi-cycle multiplier.
- Sits between the instruction memory and the board display/control logic.

---
 rtl/pipe3_core_param_if.sv | 52 +++++
 rtl/pipe3_core_param.sv | 258 +++++++++++++++++++++++++
 tb/tb_pipe3_core_param.sv | 368 ++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/pipe3_core_param_if.sv
// rtl/pipe3_core_param_if.sv - fetch, debug and writeback bus of pipe3_core_param
//
// Purpose: groups every non-clock/reset signal of the core into one bundle.
// Ports (seen from the core, modport master):
//   imem_addr  out PC_W    fetch address (current PC)
//   imem_data  in  16      instruction at imem_addr, same-cycle read
//   dbg_sel    in  4       register index for debug read
//   dbg_data   out DATA_W  R[dbg_sel]
//   wb_en      out 1       writeback strobe
//   wb_rd      out 4       writeback register index
//   wb_data    out DATA_W  writeback value
//   stall      out 1       decode interlock active
//   mult_busy  out 1       multiplier running
// The slave modport is the environment side (memory, display, control).
interface pipe3_core_param_if #(
    parameter int DATA_W = 16,
    parameter int PC_W   = 12
);
    logic [PC_W-1:0]   imem_addr;
    logic [15:0]       imem_data;
    logic [3:0]        dbg_sel;
    logic [DATA_W-1:0] dbg_data;
    logic              wb_en;
    logic [3:0]        wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              stall;
    logic              mult_busy;

    modport master (
        output imem_addr,
        input  imem_data,
        input  dbg_sel,
        output dbg_data,
        output wb_en,
        output wb_rd,
        output wb_data,
        output stall,
        output mult_busy
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        output dbg_sel,
        input  dbg_data,
        input  wb_en,
        input  wb_rd,
        input  wb_data,
        input  stall,
        input  mult_busy
    );
endinterface

// File: rtl/pipe3_core_param.sv
// rtl/pipe3_core_param.sv - parametrised 3-stage (decode/execute/writeback) 16-bit-instruction core
//
// Purpose: decode reads the instruction and register file into DX, execute
// computes the ALU result into XW and resolves jumps/branches, writeback
// commits XW to the register file. Full forwarding, one-bubble flush on taken
// control flow, interlock of MUL/MFLO/MFHI against the multi-cycle multiplier.
// Ports:
//   clk    in  core clock
//   reset  in  synchronous active-high reset (overrides run)
//   run    in  global enable; 0 freezes every state element
//   bus    pipe3_core_param_if.master (fetch, debug read, writeback, status)
module pipe3_core_param #(
    parameter int DATA_W      = 16,
    parameter int PC_W        = 12,
    parameter int MULT_CYCLES = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    pipe3_core_param_if.master bus
);
    localparam int CNT_W = (MULT_CYCLES > 1) ? $clog2(MULT_CYCLES) : 1;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_SGTI = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_ANDI = 4'h6;
    localparam logic [3:0] OP_ORI  = 4'h7;
    localparam logic [3:0] OP_XORI = 4'h8;
    localparam logic [3:0] OP_ADDI = 4'h9;
    localparam logic [3:0] OP_SUBI = 4'hA;
    localparam logic [3:0] OP_JMP  = 4'hB;
    localparam logic [3:0] OP_BEZ  = 4'hC;
    localparam logic [3:0] OP_MFLO = 4'hD;
    localparam logic [3:0] OP_MFHI = 4'hE;
    localparam logic [3:0] OP_MUL  = 4'hF;

    typedef enum logic {
        M_IDLE,
        M_BUSY
    } mult_state_t;

    // Architectural and pipeline state
    logic [PC_W-1:0]     pc;
    logic [DATA_W-1:0]   regs [16];

    logic                dx_valid;
    logic [15:0]         dx_instr;
    logic [PC_W-1:0]     dx_pc;
    logic [DATA_W-1:0]   dx_a;      // R[rs]
    logic [DATA_W-1:0]   dx_b;      // R[rt]
    logic [DATA_W-1:0]   dx_d;      // R[rd], the BEZ test operand

    logic                xw_valid;
    logic                xw_we;
    logic [3:0]          xw_rd;
    logic [DATA_W-1:0]   xw_data;

    mult_state_t         m_state;
    logic [CNT_W-1:0]    m_cnt;
    logic [DATA_W-1:0]   m_a;
    logic [DATA_W-1:0]   m_b;
    logic [2*DATA_W-1:0] product;

    // ---------------- Decode ----------------
    logic [15:0]       d_instr;
    logic [3:0]        d_op;
    logic [3:0]        d_rd;
    logic [3:0]        d_rs;
    logic [3:0]        d_rt;
    logic              wb_fire;
    logic [DATA_W-1:0] d_a;
    logic [DATA_W-1:0] d_b;
    logic [DATA_W-1:0] d_d;
    logic              d_uses_mult;
    logic              dx_is_mul;
    logic              mult_busy_i;
    logic              stall_i;

    assign d_instr = bus.imem_data;
    assign d_op    = d_instr[15:12];
    assign d_rd    = d_instr[11:8];
    assign d_rs    = d_instr[7:4];
    assign d_rt    = d_instr[3:0];

    assign wb_fire = xw_valid & xw_we;

    // Write-first read: the value being committed this edge is what decode sees.
    assign d_a = (wb_fire && xw_rd == d_rs) ? xw_data : regs[d_rs];
    assign d_b = (wb_fire && xw_rd == d_rt) ? xw_data : regs[d_rt];
    assign d_d = (wb_fire && xw_rd == d_rd) ? xw_data : regs[d_rd];

    assign mult_busy_i = (m_state == M_BUSY);
    assign dx_is_mul   = dx_valid && (dx_instr[15:12] == OP_MUL);
    assign d_uses_mult = (d_op == OP_MUL) || (d_op == OP_MFLO) || (d_op == OP_MFHI);
    // A MUL sitting in DX will start the multiplier at this edge, so anything
    // touching the product must wait just as if the unit were already busy.
    assign stall_i     = d_uses_mult && (mult_busy_i || dx_is_mul);

    // ---------------- Execute ----------------
    logic [3:0]        x_op;
    logic [3:0]        x_rd;
    logic [3:0]        x_rs;
    logic [3:0]        x_rt;
    logic              xw_hit;
    logic [DATA_W-1:0] x_a;
    logic [DATA_W-1:0] x_b;
    logic [DATA_W-1:0] x_d;
    logic [DATA_W-1:0] x_imm;
    logic [DATA_W-1:0] x_res;
    logic              x_we;
    logic              x_branch;
    logic              flush;
    logic [PC_W-1:0]   x_target;
    logic [PC_W+11:0]  jmp_ext;
    logic [PC_W+7:0]   bez_off;
    logic              mult_start;

    assign x_op  = dx_instr[15:12];
    assign x_rd  = dx_instr[11:8];
    assign x_rs  = dx_instr[7:4];
    assign x_rt  = dx_instr[3:0];
    assign x_imm = {{(DATA_W-4){1'b0}}, x_rs};

    // XW holds the immediately preceding instruction; it overrides what DX captured.
    assign xw_hit = xw_valid & xw_we;
    assign x_a = (xw_hit && xw_rd == x_rs) ? xw_data : dx_a;
    assign x_b = (xw_hit && xw_rd == x_rt) ? xw_data : dx_b;
    assign x_d = (xw_hit && xw_rd == x_rd) ? xw_data : dx_d;

    // Extend-then-truncate handles PC_W both narrower and wider than the field.
    assign jmp_ext = {{PC_W{1'b0}}, dx_instr[11:0]};
    assign bez_off = {{PC_W{dx_instr[7]}}, dx_instr[7:0]};

    always_comb begin
        x_res    = '0;
        x_we     = 1'b1;
        x_branch = 1'b0;
        x_target = jmp_ext[PC_W-1:0];
        case (x_op)
            OP_ADD:  x_res = x_a + x_b;
            OP_SUB:  x_res = x_a - x_b;
            OP_SGTI: x_res = {{(DATA_W-1){1'b0}}, (x_b > x_imm)};
            OP_AND:  x_res = x_a & x_b;
            OP_OR:   x_res = x_a | x_b;
            OP_XOR:  x_res = x_a ^ x_b;
            OP_ANDI: x_res = x_b & x_imm;
            OP_ORI:  x_res = x_b | x_imm;
            OP_XORI: x_res = x_b ^ x_imm;
            OP_ADDI: x_res = x_b + x_imm;
            OP_SUBI: x_res = x_b - x_imm;
            OP_JMP: begin
                x_we     = 1'b0;
                x_branch = 1'b1;
            end
            OP_BEZ: begin
                x_we     = 1'b0;
                x_branch = (x_d == '0);
                x_target = dx_pc + PC_W'(1) + bez_off[PC_W-1:0];
            end
            OP_MFLO: x_res = product[DATA_W-1:0];
            OP_MFHI: x_res = product[2*DATA_W-1:DATA_W];
            default: x_we  = 1'b0;   // MUL: result lands in the product register
        endcase
    end

    assign flush      = dx_valid & x_branch;
    assign mult_start = dx_valid && (x_op == OP_MUL);

    // ---------------- Pipeline registers and register file ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            pc       <= '0;
            dx_valid <= 1'b0;
            dx_instr <= '0;
            dx_pc    <= '0;
            dx_a     <= '0;
            dx_b     <= '0;
            dx_d     <= '0;
            xw_valid <= 1'b0;
            xw_we    <= 1'b0;
            xw_rd    <= '0;
            xw_data  <= '0;
            for (int i = 0; i < 16; i++) begin
                regs[i] <= '0;
            end
        end else if (run) begin
            if (wb_fire) begin
                regs[xw_rd] <= xw_data;
            end

            xw_valid <= dx_valid;
            xw_we    <= dx_valid & x_we;
            // wb_rd/wb_data keep the last real writeback across bubbles.
            if (dx_valid && x_we) begin
                xw_rd   <= x_rd;
                xw_data <= x_res;
            end

            // Flush beats stall: the held instruction is on the wrong path anyway.
            dx_valid <= !(flush || stall_i);
            dx_instr <= d_instr;
            dx_pc    <= pc;
            dx_a     <= d_a;
            dx_b     <= d_b;
            dx_d     <= d_d;

            if (flush) begin
                pc <= x_target;
            end else if (!stall_i) begin
                pc <= pc + PC_W'(1);
            end
        end
    end

    // ---------------- Multiplier FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            m_state <= M_IDLE;
            m_cnt   <= '0;
            m_a     <= '0;
            m_b     <= '0;
            product <= '0;
        end else if (run) begin
            case (m_state)
                M_IDLE: begin
                    if (mult_start) begin
                        m_state <= M_BUSY;
                        m_a     <= x_a;
                        m_b     <= x_b;
                        m_cnt   <= CNT_W'(MULT_CYCLES - 1);
                    end
                end
                M_BUSY: begin
                    if (m_cnt == '0) begin
                        product <= (2*DATA_W)'(m_a) * (2*DATA_W)'(m_b);
                        m_state <= M_IDLE;
                    end else begin
                        m_cnt <= m_cnt - CNT_W'(1);
                    end
                end
                default: m_state <= M_IDLE;
            endcase
        end
    end

    // ---------------- Outputs ----------------
    assign bus.imem_addr = pc;
    assign bus.dbg_data  = regs[bus.dbg_sel];
    assign bus.wb_en     = run & wb_fire;
    assign bus.wb_rd     = xw_rd;
    assign bus.wb_data   = xw_data;
    assign bus.stall     = stall_i;
    assign bus.mult_busy = mult_busy_i;
endmodule

// File: tb/tb_pipe3_core_param.sv
// tb/tb_pipe3_core_param.sv - self-checking bench for pipe3_core_param
module tb_pipe3_core_param;
    localparam int DW = 16;
    localparam int MC = 4;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset = 1'b1;
    logic run   = 1'b0;
    logic [3:0] dbg_sel   = '0;
    logic [3:0] dbg_sel32 = '0;

    logic [15:0] imem   [4096];
    logic [15:0] imem32 [4096];

    pipe3_core_param_if #(.DATA_W(DW), .PC_W(12)) bus ();
    pipe3_core_param_if #(.DATA_W(32), .PC_W(12)) bus32 ();

    assign bus.imem_data   = imem[bus.imem_addr];
    assign bus.dbg_sel     = dbg_sel;
    assign bus32.imem_data = imem32[bus32.imem_addr];
    assign bus32.dbg_sel   = dbg_sel32;

    pipe3_core_param #(.DATA_W(DW), .PC_W(12), .MULT_CYCLES(MC)) u_dut (
        .clk   (clk),
        .reset (reset),
        .run   (run),
        .bus   (bus)
    );

    pipe3_core_param #(.DATA_W(32), .PC_W(12), .MULT_CYCLES(1)) u_dut32 (
        .clk   (clk),
        .reset (reset),
        .run   (run),
        .bus   (bus32)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- Monitor ----------------
    int cyc, stall_cnt, busy_cnt;
    int addr_q[$];
    int wb_rd_q[$];
    int wb_cyc_q[$];
    logic [63:0] wb_data_q[$];
    bit rnd_on = 1'b0;

    // ISA-level reference: executes instructions one at a time in program order.
    int              m_pc;
    logic [DW-1:0]   m_r [16];
    logic [2*DW-1:0] m_prod;

    task automatic model_next_write(output int rd_o, output logic [63:0] d_o, output bit found);
        logic [15:0] ins;
        int op, rd, rs, rt, nxt;
        logic [DW-1:0] a, b, imm, res;
        bit wr;
        found = 1'b0;
        rd_o  = 0;
        d_o   = '0;
        for (int n = 0; n < 4000 && !found; n++) begin
            ins = imem[m_pc];
            op  = int'(ins[15:12]);
            rd  = int'(ins[11:8]);
            rs  = int'(ins[7:4]);
            rt  = int'(ins[3:0]);
            a   = m_r[rs];
            b   = m_r[rt];
            imm = DW'(rs);
            res = '0;
            wr  = 1'b1;
            nxt = (m_pc + 1) % 4096;
            case (op)
                0:  res = a + b;
                1:  res = a - b;
                2:  res = (b > imm) ? DW'(1) : DW'(0);
                3:  res = a & b;
                4:  res = a | b;
                5:  res = a ^ b;
                6:  res = b & imm;
                7:  res = b | imm;
                8:  res = b ^ imm;
                9:  res = b + imm;
                10: res = b - imm;
                11: begin wr = 1'b0; nxt = int'(ins[11:0]); end
                12: begin
                    wr = 1'b0;
                    if (m_r[rd] == 0) nxt = (m_pc + 1 + int'($signed(ins[7:0])) + 4096) % 4096;
                end
                13: res = m_prod[DW-1:0];
                14: res = m_prod[2*DW-1:DW];
                default: begin
                    wr = 1'b0;
                    m_prod = (2*DW)'(longint'(a) * longint'(b));
                end
            endcase
            m_pc = nxt;
            if (wr) begin
                m_r[rd] = res;
                found   = 1'b1;
                rd_o    = rd;
                d_o     = 64'(res);
            end
        end
    endtask

    int          mon_rd;
    logic [63:0] mon_d;
    bit          mon_ok;

    always @(negedge clk) begin
        if (!reset && run) begin
            cyc++;
            addr_q.push_back(int'(bus.imem_addr));
            if (bus.stall) stall_cnt++;
            if (bus.mult_busy) busy_cnt++;
            if (bus.wb_en) begin
                wb_rd_q.push_back(int'(bus.wb_rd));
                wb_data_q.push_back(64'(bus.wb_data));
                wb_cyc_q.push_back(cyc);
                if (rnd_on) begin
                    model_next_write(mon_rd, mon_d, mon_ok);
                    check("rnd_model_found", 64'(mon_ok), 64'(1));
                    check("rnd_wb_rd", 64'(bus.wb_rd), 64'(mon_rd));
                    check("rnd_wb_data", 64'(bus.wb_data), mon_d);
                end
            end
        end
    end

    // ---------------- Helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        cyc = 0; stall_cnt = 0; busy_cnt = 0;
        addr_q.delete(); wb_rd_q.delete(); wb_data_q.delete(); wb_cyc_q.delete();
    endtask

    task automatic fill_imem();
        for (int i = 0; i < 4096; i++) imem[i] = 16'hB000 | 16'(i);   // jump-to-self idle
    endtask

    task automatic do_reset();
        reset = 1'b1; run = 1'b1;
        tick();
        reset = 1'b0;
        clear_mon();
    endtask

    task automatic read_dbg(input int idx, output logic [63:0] v);
        dbg_sel = 4'(idx);
        #1;
        v = 64'(bus.dbg_data);
    endtask

    task automatic read_dbg32(input int idx, output logic [63:0] v);
        dbg_sel32 = 4'(idx);
        #1;
        v = 64'(bus32.dbg_data);
    endtask

    function automatic int find_addr(input int a);
        for (int i = 0; i < addr_q.size(); i++) if (addr_q[i] == a) return i;
        return -1;
    endfunction

    function automatic int find_wb(input int rd);
        for (int i = 0; i < wb_rd_q.size(); i++) if (wb_rd_q[i] == rd) return i;
        return -1;
    endfunction

    task automatic load_mul_prog(input logic [15:0] ld1, input logic [15:0] ld2);
        fill_imem();
        imem[0] = ld1;
        imem[1] = ld2;
        imem[2] = 16'hF012;   // MUL r1*r2
        imem[3] = 16'hD300;   // MFLO r3
        imem[4] = 16'hE400;   // MFHI r4
    endtask

    int          t1_rd   [4] = '{1, 2, 3, 4};
    int          t1_data [4] = '{5, 10, 5, 1};
    logic [63:0] v;
    int          idx, k, frozen_pc;

    initial begin
        #1_000_000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        fill_imem();
        for (int i = 0; i < 4096; i++) imem32[i] = 16'hB000 | 16'(i);
        imem32[0] = 16'h9150; imem32[1] = 16'h0211; imem32[2] = 16'h1321;
        imem32[3] = 16'h2433; imem32[4] = 16'hA810;   // r8 = 0 - 1

        // Reset state, with run low (reset must override it)
        reset = 1'b1; run = 1'b0;
        tick();
        check("rst_wb_en", 64'(bus.wb_en), 64'(0));
        check("rst_wb_rd", 64'(bus.wb_rd), 64'(0));
        check("rst_wb_data", 64'(bus.wb_data), 64'(0));
        check("rst_stall", 64'(bus.stall), 64'(0));
        check("rst_mult_busy", 64'(bus.mult_busy), 64'(0));
        check("rst_pc", 64'(bus.imem_addr), 64'(0));

        // 1. Forwarding chain
        fill_imem();
        imem[0] = 16'h9150; imem[1] = 16'h0211; imem[2] = 16'h1321; imem[3] = 16'h2433;
        do_reset();
        repeat (12) tick();
        check("t1_wb_count", 64'(wb_rd_q.size()), 64'(4));
        for (int i = 0; i < 4; i++) begin
            if (i < wb_rd_q.size()) begin
                check("t1_wb_rd", 64'(wb_rd_q[i]), 64'(t1_rd[i]));
                check("t1_wb_data", wb_data_q[i], 64'(t1_data[i]));
                check("t1_wb_cycle", 64'(wb_cyc_q[i]), 64'(3 + i));
            end
        end
        check("t1_no_stall", 64'(stall_cnt), 64'(0));
        for (int i = 0; i < 4; i++) begin
            read_dbg(t1_rd[i], v);
            check("t1_reg", v, 64'(t1_data[i]));
            read_dbg32(t1_rd[i], v);
            check("t1_reg_w32", v, 64'(t1_data[i]));
        end
        read_dbg32(8, v);
        check("t1_w32_wrap", v, 64'h0000_0000_FFFF_FFFF);

        // 2. JMP flush
        fill_imem();
        imem[0] = 16'hB003; imem[3] = 16'hB008; imem[4] = 16'h9510; imem[8] = 16'h9620;
        do_reset();
        repeat (12) tick();
        idx = find_addr(3);
        check("t2_saw_3", 64'(idx >= 0), 64'(1));
        if (idx >= 0 && idx + 2 < addr_q.size()) begin
            check("t2_addr_next", 64'(addr_q[idx+1]), 64'(4));
            check("t2_addr_target", 64'(addr_q[idx+2]), 64'(8));
        end
        check("t2_r5_no_wb", 64'(find_wb(5)), 64'(-1));
        read_dbg(5, v); check("t2_r5", v, 64'(0));
        read_dbg(6, v); check("t2_r6", v, 64'(2));

        // 3a. BEZ taken
        fill_imem();
        imem[0] = 16'hB005; imem[5] = 16'hC702; imem[6] = 16'h9510; imem[8] = 16'h9620;
        do_reset();
        repeat (12) tick();
        idx = find_addr(5);
        if (idx >= 0 && idx + 2 < addr_q.size()) begin
            check("t3a_addr_next", 64'(addr_q[idx+1]), 64'(6));
            check("t3a_addr_target", 64'(addr_q[idx+2]), 64'(8));
        end else check("t3a_saw_5", 64'(idx), 64'(2));
        read_dbg(5, v); check("t3a_r5", v, 64'(0));
        read_dbg(6, v); check("t3a_r6", v, 64'(2));

        // 3b. BEZ not taken
        fill_imem();
        imem[0] = 16'h9710; imem[1] = 16'hB005; imem[5] = 16'hC702;
        imem[6] = 16'h9510; imem[8] = 16'h9620;
        do_reset();
        repeat (14) tick();
        idx = find_addr(5);
        if (idx >= 0 && idx + 2 < addr_q.size()) begin
            check("t3b_addr_next", 64'(addr_q[idx+1]), 64'(6));
            check("t3b_addr_next2", 64'(addr_q[idx+2]), 64'(7));
            k = find_wb(5);
            if (k >= 0) check("t3b_r5_wb_cycle", 64'(wb_cyc_q[k]), 64'(idx + 4));
            else check("t3b_r5_wb_seen", 64'(k), 64'(0));
        end else check("t3b_saw_5", 64'(idx), 64'(3));
        read_dbg(5, v); check("t3b_r5", v, 64'(1));
        read_dbg(6, v); check("t3b_r6", v, 64'(0));

        // 4. Multiplier, small and full-scale operands
        load_mul_prog(16'h9130, 16'h9270);
        do_reset();
        repeat (20) tick();
        check("t4_stall_cycles", 64'(stall_cnt), 64'(MC + 1));
        check("t4_busy_cycles", 64'(busy_cnt), 64'(MC));
        read_dbg(3, v); check("t4_lo", v, 64'(21));
        read_dbg(4, v); check("t4_hi", v, 64'(0));

        load_mul_prog(16'hA110, 16'hA210);
        do_reset();
        repeat (20) tick();
        read_dbg(3, v); check("t4_lo_max", v, 64'h0001);
        read_dbg(4, v); check("t4_hi_max", v, 64'hFFFE);

        // 5. run=0 for 3 cycles in the middle of a multiply
        load_mul_prog(16'h9130, 16'h9270);
        do_reset();
        k = 0;
        while (!bus.mult_busy && k < 20) begin tick(); k++; end
        check("t5_busy_seen", 64'(bus.mult_busy), 64'(1));
        tick();
        frozen_pc = int'(bus.imem_addr);
        run = 1'b0;
        repeat (3) begin
            tick();
            check("t5_pc_frozen", 64'(bus.imem_addr), 64'(frozen_pc));
            check("t5_busy_frozen", 64'(bus.mult_busy), 64'(1));
            check("t5_wb_en_off", 64'(bus.wb_en), 64'(0));
        end
        run = 1'b1;
        repeat (20) tick();
        check("t5_busy_cycles", 64'(busy_cnt), 64'(MC));
        check("t5_stall_cycles", 64'(stall_cnt), 64'(MC + 1));
        read_dbg(3, v); check("t5_lo", v, 64'(21));
        read_dbg(4, v); check("t5_hi", v, 64'(0));

        // 6. Reset while the multiplier is busy
        load_mul_prog(16'h9130, 16'h9270);
        do_reset();
        k = 0;
        while (!bus.mult_busy && k < 20) begin tick(); k++; end
        check("t6_busy_seen", 64'(bus.mult_busy), 64'(1));
        reset = 1'b1;
        tick();
        check("t6_mult_busy", 64'(bus.mult_busy), 64'(0));
        check("t6_pc", 64'(bus.imem_addr), 64'(0));
        check("t6_wb_en", 64'(bus.wb_en), 64'(0));
        for (int r = 0; r < 16; r++) begin
            read_dbg(r, v);
            check("t6_reg_zero", v, 64'(0));
        end
        reset = 1'b0;

        // 7. Random programs against the ISA-level model, with random run gaps
        for (int round = 0; round < 4; round++) begin
            for (int i = 0; i < 4096; i++) imem[i] = 16'($urandom);
            do_reset();
            m_pc = 0;
            m_prod = '0;
            for (int r = 0; r < 16; r++) m_r[r] = '0;
            rnd_on = 1'b1;
            repeat (700) begin
                run = ($urandom_range(0, 9) != 0);
                tick();
            end
            run = 1'b0;
            tick();
            rnd_on = 1'b0;
            for (int r = 0; r < 16; r++) begin
                read_dbg(r, v);
                check("rnd_final_reg", v, 64'(m_r[r]));
            end
            run = 1'b1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
